// File: rtl/dram_fifo.sv
// First-word-fall-through FIFO controller around a dual-port RAM: registered
// write port takes pushes, asynchronous read port presents the head entry.

module dram #(
  parameter int SZ = 16,
  parameter int DW = 32
) (
  input  logic                  clk_i,
  input  logic [$clog2(SZ)-1:0] addr0_i,
  output logic [DW-1:0]         data0_o,
  input  logic                  we1_i,
  input  logic [$clog2(SZ)-1:0] addr1_i,
  input  logic [DW-1:0]         data1_i
);

  logic [DW-1:0] mem [SZ];

  assign data0_o = mem[addr0_i];

  always_ff @(posedge clk_i) begin
    if (we1_i) mem[addr1_i] <= data1_i;
  end

endmodule

module dram_fifo #(
  parameter int SZ    = 16,
  parameter int DW    = 32,
  parameter int AFULL = SZ - 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DW-1:0]         data_i,
  output logic                  full_o,
  output logic                  afull_o,
  input  logic                  pop_i,
  output logic [DW-1:0]         data_o,
  output logic                  empty_o,
  output logic [$clog2(SZ):0]   level_o
);

  localparam int AW = $clog2(SZ);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_LV = PW'(AFULL);

  // MSB of each pointer is the wrap bit; low AW bits address the RAM
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          push_acc;
  logic          pop_acc;

  assign level_o = wp - rp;
  assign empty_o = (wp == rp);
  assign full_o  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign afull_o = (level_o >= AFULL_LV);

  assign push_acc = push_i & ~full_o & ~flush_i;
  assign pop_acc  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
    end else if (flush_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_acc) wp <= wp + PW'(1);
      if (pop_acc)  rp <= rp + PW'(1);
    end
  end

  dram #(
    .SZ (SZ),
    .DW (DW)
  ) u_dram (
    .clk_i   (clk_i),
    .addr0_i (rp[AW-1:0]),
    .data0_o (data_o),
    .we1_i   (push_acc),
    .addr1_i (wp[AW-1:0]),
    .data1_i (data_i)
  );

endmodule

// File: tb/tb_dram_fifo.sv
// Directed bench for dram_fifo with SZ=4, DW=8 (AFULL defaults to 3).

module tb_dram_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       push_i;
  logic [7:0] data_i;
  logic       full_o;
  logic       afull_o;
  logic       pop_i;
  logic [7:0] data_o;
  logic       empty_o;
  logic [2:0] level_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  dram_fifo #(.SZ(4), .DW(8)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push_i),
    .data_i  (data_i),
    .full_o  (full_o),
    .afull_o (afull_o),
    .pop_i   (pop_i),
    .data_o  (data_o),
    .empty_o (empty_o),
    .level_o (level_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, return #1 after the edge with inputs idle
  task automatic step(input logic push, input logic [7:0] d, input logic pop, input logic flush);
    push_i  = push;
    data_i  = d;
    pop_i   = pop;
    flush_i = flush;
    @(posedge clk_i);
    #1;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int lvl, input logic e, input logic f, input logic af);
    chk({tag, "_level"}, 32'(level_o), 32'(lvl));
    chk({tag, "_empty"}, 32'(empty_o), 32'(e));
    chk({tag, "_full"},  32'(full_o),  32'(f));
    chk({tag, "_afull"}, 32'(afull_o), 32'(af));
  endtask

  logic [7:0] fill_d [4];
  int         toggles;
  logic       wrap0;

  initial begin
    fill_d[0] = 8'h11; fill_d[1] = 8'h22; fill_d[2] = 8'h33; fill_d[3] = 8'h44;
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    data_i  = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    chk_status("reset", 0, 1'b1, 1'b0, 1'b0);
    rst_ni = 1'b1;

    // fill
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fill_d[i], 1'b0, 1'b0);
      chk_status($sformatf("fill%0d", i), i + 1, 1'b0, (i == 3), (i >= 2));
      chk($sformatf("fill%0d_data", i), 32'(data_o), 32'h11);
    end

    // overflow ignored
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk_status("ovf", 4, 1'b0, 1'b1, 1'b1);
    chk("ovf_data", 32'(data_o), 32'h11);

    // drain
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_data", i), 32'(data_o), 32'(fill_d[i]));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk_status($sformatf("drain%0d", i), 3 - i, (i == 3), 1'b0, (i == 0));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_status("udf", 0, 1'b1, 1'b0, 1'b0);

    // push+pop at empty
    step(1'b1, 8'hA0, 1'b1, 1'b0);
    chk_status("pp_empty", 1, 1'b0, 1'b0, 1'b0);
    chk("pp_empty_data", 32'(data_o), 32'hA0);
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'hB3, 1'b0, 1'b0);
    chk_status("pp_fill", 4, 1'b0, 1'b1, 1'b1);

    // push+pop at full: pop only
    step(1'b1, 8'hB0, 1'b1, 1'b0);
    chk_status("pp_full", 3, 1'b0, 1'b0, 1'b1);
    chk("pp_full_d0", 32'(data_o), 32'hB1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_full_d1", 32'(data_o), 32'hB2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_full_d2", 32'(data_o), 32'hB3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_status("pp_full_drain", 0, 1'b1, 1'b0, 1'b0);

    // push+pop at level 2
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    chk_status("pp_mid", 2, 1'b0, 1'b0, 1'b0);
    chk("pp_mid_d0", 32'(data_o), 32'hC2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_mid_d1", 32'(data_o), 32'hC3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_mid_empty", 32'(empty_o), 32'h1);

    // wrap-around: prime with 0, then push i+1 while popping i
    step(1'b1, 8'd0, 1'b0, 1'b0);
    wrap0   = dut.wp[2];
    toggles = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap%0d_data", i), 32'(data_o), 32'(i));
      step((i < 9), 8'(i + 1), 1'b1, 1'b0);
      if (dut.wp[2] != wrap0) toggles++;
      if (i < 9) begin
        chk($sformatf("wrap%0d_level", i), 32'(level_o), 32'd1);
        chk($sformatf("wrap%0d_full", i), 32'(full_o), 32'd0);
      end
    end
    chk("wrap_toggled", 32'(toggles > 0), 32'd1);
    chk("wrap_end_empty", 32'(empty_o), 32'd1);

    // flush with push at level 3
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b0, 1'b0);
    step(1'b1, 8'hD3, 1'b0, 1'b0);
    chk_status("pre_flush", 3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hD4, 1'b0, 1'b1);
    chk_status("flush", 0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hE1, 1'b0, 1'b0);
    chk_status("post_flush", 1, 1'b0, 1'b0, 1'b0);
    chk("post_flush_data", 32'(data_o), 32'hE1);

    // async reset between edges at level 2
    step(1'b1, 8'hE2, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level_o), 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_status("async_rst", 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step(1'b1, 8'hF1, 1'b0, 1'b0);
    chk_status("post_rst", 1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", 32'(data_o), 32'hF1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
